// File: rtl/cellrv32_fifo_level.sv
`default_nettype none
// ============================================================================
//  Module   : cellrv32_fifo_level
//  Purpose  : Single-clock synchronous FIFO of arbitrary (non power-of-two)
//             depth with first-word-fall-through read data, an exact fill
//             level, run-time programmable almost-full / almost-empty
//             watermarks, a half-full flag and optional sticky
//             overflow/underflow error flags.
//
//  Parameters
//    FIFO_DEPTH : number of entries, 2..1024
//    FIFO_WIDTH : data width in bits, 1..64
//    FULL_RW    : 1 = a write to a full FIFO is accepted when a read is
//                 accepted in the same cycle; 0 = always rejected
//    LW         : derived, $clog2(FIFO_DEPTH+1); width of level/thresholds
//
//  Ports
//    clk_i        in   clock, rising edge
//    rstn_i       in   asynchronous active-low reset
//    clear_i      in   synchronous clear (pointers, level, error flags)
//    wdata_i      in   write data
//    we_i         in   write request
//    free_o       out  at least one entry free
//    re_i         in   read request, pops current head
//    rdata_o      out  head data, all-zero when empty
//    avail_o      out  at least one entry valid
//    level_o      out  number of valid entries, 0..FIFO_DEPTH
//    afull_thr_i  in   almost-full threshold  (afull_o  = level >= thr)
//    aempty_thr_i in   almost-empty threshold (aempty_o = level <= thr)
//    half_o       out  2*level >= FIFO_DEPTH
//    err_clr_i    in   clears the sticky error flags
//    ovf_o        out  sticky overflow (a write was rejected)
//    udf_o        out  sticky underflow (a read was issued while empty)
//
//  Build option
//    CELLRV32_FIFO_LEVEL_ERR_EN : when defined, the ovf/udf sticky flags and
//                                 err_clr_i are implemented; otherwise
//                                 ovf_o/udf_o are tied low.
//
//  Revision : 1.0 - initial release
// ============================================================================
module cellrv32_fifo_level #(
    parameter int   FIFO_DEPTH = 4,
    parameter int   FIFO_WIDTH = 32,
    parameter logic FULL_RW    = 1'b1,
    localparam int  LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic [FIFO_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    output logic                  free_o,
    input  logic                  re_i,
    output logic [FIFO_WIDTH-1:0] rdata_o,
    output logic                  avail_o,
    output logic [LW-1:0]         level_o,
    input  logic [LW-1:0]         afull_thr_i,
    input  logic [LW-1:0]         aempty_thr_i,
    output logic                  afull_o,
    output logic                  aempty_o,
    output logic                  half_o,
    input  logic                  err_clr_i,
    output logic                  ovf_o,
    output logic                  udf_o
);

    // Pointer width; depth is at least 2 so $clog2 is never zero.
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [LW-1:0] C_LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [PW-1:0] C_PNT_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [LW:0]   C_HALF_CMP = (LW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [FIFO_WIDTH-1:0] mem_q [0:FIFO_DEPTH-1];
    logic [PW-1:0]         w_pnt_q, w_pnt_d;
    logic [PW-1:0]         r_pnt_q, r_pnt_d;
    logic [LW-1:0]         level_q, level_d;

    logic w_full;
    logic w_avail;
    logic w_re_acc;
    logic w_we_acc;

    // Pointers wrap explicitly at FIFO_DEPTH-1 so any depth is supported.
    function automatic logic [PW-1:0] f_pnt_inc(input logic [PW-1:0] p);
        return (p == C_PNT_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Access qualification: full/empty come from the level counter only.
    // ------------------------------------------------------------------------
    assign w_full   = (level_q == C_LVL_FULL);
    assign w_avail  = (level_q != '0);
    assign w_re_acc = re_i & w_avail;
    // A write into a full FIFO may ride along with an accepted read, since
    // the read frees the slot the write pointer currently addresses.
    assign w_we_acc = we_i & (~w_full | (FULL_RW & w_re_acc));

    always_comb begin
        w_pnt_d = w_pnt_q;
        r_pnt_d = r_pnt_q;
        level_d = level_q;
        if (w_we_acc) begin
            w_pnt_d = f_pnt_inc(w_pnt_q);
        end
        if (w_re_acc) begin
            r_pnt_d = f_pnt_inc(r_pnt_q);
        end
        case ({w_we_acc, w_re_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            w_pnt_q <= '0;
            r_pnt_q <= '0;
            level_q <= '0;
        end else if (clear_i) begin
            w_pnt_q <= '0;
            r_pnt_q <= '0;
            level_q <= '0;
        end else begin
            w_pnt_q <= w_pnt_d;
            r_pnt_q <= r_pnt_d;
            level_q <= level_d;
        end
    end

    // Data storage carries no reset; a clear cycle suppresses the write.
    always_ff @(posedge clk_i) begin
        if (w_we_acc && !clear_i) begin
            mem_q[w_pnt_q] <= wdata_i;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign free_o   = ~w_full;
    assign avail_o  = w_avail;
    assign level_o  = level_q;
    assign rdata_o  = w_avail ? mem_q[r_pnt_q] : '0;

    assign afull_o  = (level_q >= afull_thr_i);
    assign aempty_o = (level_q <= aempty_thr_i);
    // 2*level is compared one bit wider so it cannot overflow.
    assign half_o   = ({level_q, 1'b0} >= C_HALF_CMP);

    // ------------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------------
`ifdef CELLRV32_FIFO_LEVEL_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A new error event wins over a simultaneous err_clr_i.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (err_clr_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (we_i & ~w_we_acc) begin
            ovf_d = 1'b1;
        end
        if (re_i & ~w_avail) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (clear_i) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr_i;
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cellrv32_fifo_level.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cellrv32_fifo_level
//  Purpose  : Directed self-checking bench for cellrv32_fifo_level with
//             FIFO_DEPTH = 5, FIFO_WIDTH = 8. Instance A uses FULL_RW = 1,
//             instance B uses FULL_RW = 0. Expected error-flag values follow
//             the CELLRV32_FIFO_LEVEL_ERR_EN build option.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cellrv32_fifo_level;

`ifdef CELLRV32_FIFO_LEVEL_ERR_EN
    localparam logic C_ERR = 1'b1;
`else
    localparam logic C_ERR = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] wdata = '0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] afull_thr = 3'd4;
    logic [2:0] aempty_thr = 3'd1;

    logic       free, avail, afull, aempty, half, ovf, udf;
    logic [7:0] rdata;
    logic [2:0] level;

    logic       b_we = 1'b0;
    logic       b_re = 1'b0;
    logic [7:0] b_wdata = '0;
    logic       b_free, b_avail, b_afull, b_aempty, b_half, b_ovf, b_udf;
    logic [7:0] b_rdata;
    logic [2:0] b_level;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    cellrv32_fifo_level #(.FIFO_DEPTH(5), .FIFO_WIDTH(8), .FULL_RW(1'b1)) dut_a (
        .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(clear), .wdata_i(wdata),
        .we_i(we), .free_o(free), .re_i(re), .rdata_o(rdata),
        .avail_o(avail), .level_o(level), .afull_thr_i(afull_thr),
        .aempty_thr_i(aempty_thr), .afull_o(afull), .aempty_o(aempty),
        .half_o(half), .err_clr_i(err_clr), .ovf_o(ovf), .udf_o(udf)
    );

    cellrv32_fifo_level #(.FIFO_DEPTH(5), .FIFO_WIDTH(8), .FULL_RW(1'b0)) dut_b (
        .clk_i(clk_i), .rstn_i(rstn_i), .clear_i(1'b0), .wdata_i(b_wdata),
        .we_i(b_we), .free_o(b_free), .re_i(b_re), .rdata_o(b_rdata),
        .avail_o(b_avail), .level_o(b_level), .afull_thr_i(afull_thr),
        .aempty_thr_i(aempty_thr), .afull_o(b_afull), .aempty_o(b_aempty),
        .half_o(b_half), .err_clr_i(1'b0), .ovf_o(b_ovf), .udf_o(b_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic a_op(input logic w, input logic r, input logic [7:0] d);
        we = w; re = r; wdata = d;
        tick();
        we = 1'b0; re = 1'b0;
    endtask

    task automatic b_op(input logic w, input logic r, input logic [7:0] d);
        b_we = w; b_re = r; b_wdata = d;
        tick();
        b_we = 1'b0; b_re = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [$];

        // ---------------- reset values ----------------
        tick();
        tick();
        chk("rst_level", level, 0);
        chk("rst_free", free, 1);
        chk("rst_avail", avail, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_half", half, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        chk("rst_aempty", aempty, 1);
        chk("rst_afull", afull, 0);
        rstn_i = 1'b1;
        tick();

        // ---------------- fill with thresholds ----------------
        for (int i = 1; i <= 5; i++) begin
            a_op(1'b1, 1'b0, 8'(8'h10 + i));
            chk($sformatf("fill%0d_level", i), level, i);
            chk($sformatf("fill%0d_aempty", i), aempty, (i <= 1));
            chk($sformatf("fill%0d_afull", i), afull, (i >= 4));
            chk($sformatf("fill%0d_half", i), half, (i >= 3));
            chk($sformatf("fill%0d_head", i), rdata, 8'h11);
        end
        chk("full_free", free, 0);

        // ---------------- read three ----------------
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd%0d_data", i), rdata, 8'(8'h11 + i));
            a_op(1'b0, 1'b1, 8'h00);
        end
        chk("rd3_level", level, 2);

        // ---------------- refill across the wrap ----------------
        for (int i = 0; i < 3; i++) begin
            a_op(1'b1, 1'b0, 8'(8'h16 + i));
        end
        chk("wrap_level", level, 5);
        chk("wrap_free", free, 0);

        // ---------------- full + simultaneous read/write ----------------
        chk("frw_head", rdata, 8'h14);
        a_op(1'b1, 1'b1, 8'hAA);
        chk("frw_level", level, 5);
        chk("frw_ovf", ovf, 0);

        exp_q = '{8'h15, 8'h16, 8'h17, 8'h18, 8'hAA};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain%0d_data", i), rdata, exp_q[i]);
            a_op(1'b0, 1'b1, 8'h00);
        end
        chk("drain_level", level, 0);
        chk("drain_rdata", rdata, 0);
        chk("drain_avail", avail, 0);

        // ---------------- underflow and error clearing ----------------
        a_op(1'b0, 1'b1, 8'h00);
        chk("udf_set", udf, C_ERR);
        chk("udf_level", level, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("udf_cleared", udf, 0);
        err_clr = 1'b1;
        a_op(1'b0, 1'b1, 8'h00);
        err_clr = 1'b0;
        chk("udf_set_wins", udf, C_ERR);
        // Empty with simultaneous read/write: write accepted, read rejected.
        a_op(1'b1, 1'b1, 8'h21);
        chk("erw_level", level, 1);
        chk("erw_rdata", rdata, 8'h21);
        chk("erw_udf", udf, C_ERR);

        // ---------------- synchronous clear ----------------
        a_op(1'b1, 1'b0, 8'h22);
        chk("preclr_level", level, 2);
        clear = 1'b1;
        a_op(1'b1, 1'b0, 8'h23);
        clear = 1'b0;
        chk("clr_level", level, 0);
        chk("clr_avail", avail, 0);
        chk("clr_rdata", rdata, 0);
        chk("clr_udf", udf, 0);
        a_op(1'b1, 1'b0, 8'h33);
        chk("postclr_rdata", rdata, 8'h33);
        chk("postclr_level", level, 1);

        // ---------------- FULL_RW = 0 instance ----------------
        for (int i = 1; i <= 5; i++) begin
            b_op(1'b1, 1'b0, 8'(i));
        end
        chk("b_full_level", b_level, 5);
        chk("b_full_ovf", b_ovf, 0);
        b_op(1'b1, 1'b1, 8'hAA);
        chk("b_frw_level", b_level, 4);
        chk("b_frw_ovf", b_ovf, C_ERR);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("b_rd%0d_data", i), b_rdata, i);
            b_op(1'b0, 1'b1, 8'h00);
        end
        chk("b_end_level", b_level, 0);
        chk("b_end_rdata", b_rdata, 0);
        chk("b_end_udf", b_udf, 0);

        // ---------------- asynchronous reset mid-stream ----------------
        a_op(1'b1, 1'b0, 8'h34);
        chk("prerst_level", level, 2);
        a_op(1'b0, 1'b1, 8'h00);
        a_op(1'b0, 1'b1, 8'h00);
        a_op(1'b0, 1'b1, 8'h00);
        chk("prerst_udf", udf, C_ERR);
        a_op(1'b1, 1'b0, 8'h35);
        #1 rstn_i = 1'b0;
        #2;
        chk("arst_level", level, 0);
        chk("arst_avail", avail, 0);
        chk("arst_free", free, 1);
        chk("arst_rdata", rdata, 0);
        chk("arst_udf", udf, 0);
        chk("arst_half", half, 0);
        tick();
        rstn_i = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cellrv32_fifo_level.md
# cellrv32_fifo_level

Single-clock synchronous FIFO with arbitrary (non-power-of-two) depth, an exact fill-level output, run-time programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It serves as the buffering primitive for peripherals that need watermark interrupts (UART, SPI, SLINK, DMA request queues). Data is first-word-fall-through, and the output is always gated to zero when the FIFO is empty.

## Interface
- FIFO_DEPTH, 4: number of entries; any integer 2..1024.
- FIFO_WIDTH, 32: data element width in bits, 1..64.
- FULL_RW, 1'b1: 1 = a write to a full FIFO is accepted when a read is accepted in the same cycle; 0 = writes to a full FIFO are always rejected.
- LW: derived localparam, $clog2(FIFO_DEPTH+1); width of the level and threshold signals.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear, high-active.
- wdata_i  in  FIFO_WIDTH  write data.
- we_i  in  1  write request.
- free_o  out  1  at least one entry is free.
- re_i  in  1  read request; pops the current head.
- rdata_o  out  FIFO_WIDTH  head data; all-zero when empty.
- avail_o  out  1  at least one entry is valid.
- level_o  out  LW  number of valid entries, 0..FIFO_DEPTH.
- afull_thr_i  in  LW  almost-full threshold.
- aempty_thr_i  in  LW  almost-empty threshold.
- afull_o  out  1  level_o >= afull_thr_i.
- aempty_o  out  1  level_o <= aempty_thr_i.
- half_o  out  1  2*level_o >= FIFO_DEPTH.
- err_clr_i  in  1  clears the sticky error flags.
- ovf_o  out  1  sticky overflow: a write was rejected.
- udf_o  out  1  sticky underflow: a read was issued while empty.

## Operation
- **Storage:** register array of FIFO_DEPTH entries with no reset on the data. There are no power-of-two constraints.
- **Pointers:** w_pnt and r_pnt range over 0..FIFO_DEPTH-1. A pointer at FIFO_DEPTH-1 wraps to 0 on increment.
- **Fill level:** a separate level counter (LW bits) tracks occupancy. Full and empty are derived only from the level, never from pointer comparison.
- **Read accept:** re_acc = re_i & (level != 0).
- **Write accept:** we_acc = we_i & ((level != FIFO_DEPTH) | (FULL_RW & re_acc)).
- **Level update:** +1 on we_acc only, -1 on re_acc only, unchanged on both or neither. The level never exceeds FIFO_DEPTH and never drops below 0.
- **Outputs:** free_o = (level != FIFO_DEPTH); avail_o = (level != 0).
- **Read data:** rdata_o = mem[r_pnt] when avail_o = 1, else all-zero.
- **Thresholds:** afull_o, aempty_o and half_o are combinational from the level register and the threshold inputs. Thresholds may change on any cycle.
- **Clear:** clear_i has priority over we_i and re_i. It zeroes both pointers, the level, and ovf/udf. Memory contents are untouched.
- **Error flags:** ovf sets on (we_i & ~we_acc); udf sets on (re_i & (level == 0)). Set has priority over err_clr_i in the same cycle; clear_i overrides both.
- **Illegal requests** (write when full, read when empty) are ignored and leave the pointers unchanged.

## Timing
- **Reset values:** level_o = 0, free_o = 1, avail_o = 0, rdata_o = 0, half_o = 0, ovf_o = 0, udf_o = 0. afull_o and aempty_o follow the thresholds (level is 0).
- **Write-to-read latency:** 1 cycle. Data written at edge N is visible on rdata_o, with avail_o = 1, after edge N. There is no same-cycle bypass from empty.
- **Status update:** level_o and all flags update on the same edge as the accepted access.
- **Full with simultaneous read and write (FULL_RW = 1):** level stays at FIFO_DEPTH and both pointers advance.
- **Empty with simultaneous read and write:** the read is rejected (udf sets), the write is accepted, and level becomes 1.
- **Reset mid-operation:** asserting rstn_i returns all state to its reset values immediately and asynchronously.

## Configuration
- **CELLRV32_FIFO_LEVEL_ERR_EN defined:** the ovf/udf sticky registers and err_clr_i logic are built as described above.
- **CELLRV32_FIFO_LEVEL_ERR_EN undefined:** ovf_o and udf_o are tied to 0 and err_clr_i is ignored. All other behaviour is identical.

## Test plan
- **Non-power-of-two depth and wrap:** FIFO_DEPTH = 5; write 0x11..0x15 -> level_o = 5, free_o = 0. Read 3 -> 0x11, 0x12, 0x13. Write 0x16..0x18 (pointers wrap) -> read order 0x14..0x18, then level_o = 0 and rdata_o = 0.
- **Thresholds:** afull_thr = 4, aempty_thr = 1, DEPTH = 5. Writes 1..5 -> aempty_o drops after the 2nd write; afull_o rises after the 4th; half_o rises after the 3rd.
- **Full with simultaneous read/write:** full with FULL_RW = 1, we_i = re_i = 1 with data 0xAA -> level stays 5, ovf_o = 0, and 0xAA is read last. With FULL_RW = 0 -> write is dropped, ovf_o = 1, level becomes 4.
- **Underflow and error clearing:** re_i on empty -> udf_o = 1, pointers unchanged. err_clr_i pulse -> udf_o = 0. udf set and err_clr_i in the same cycle -> udf_o = 1.
- **Clear and reset:** clear_i mid-stream with we_i = 1 -> level_o = 0, write ignored. Async rstn_i low mid-stream -> all outputs at their reset values before the next edge.
- **Macro off:** rebuild without CELLRV32_FIFO_LEVEL_ERR_EN and repeat the underflow and overflow stimulus -> ovf_o = udf_o = 0 throughout; data and level checks are unchanged.
